// File: rtl/param_digital_lock.sv
// Parameterised digital lock: entry FSM with code, attempt, inter-digit and unlock timers,
// plus in-field code reprogramming from the UNLOCKED state.
module param_digital_lock #(
  parameter int DIGIT_W     = 4,
  parameter int CODE_LEN    = 4,
  parameter logic [CODE_LEN*DIGIT_W-1:0] DEFAULT_CODE = 16'h1001,
  parameter int MAX_TRIES   = 3,
  parameter int TIMEOUT_CYC = 16,
  parameter int UNLOCK_CYC  = 8
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             start,
  input  logic                             prog_mode,
  input  logic [DIGIT_W-1:0]               digit_in,
  input  logic                             digit_valid,
  input  logic                             clear_alarm,
  output logic                             unlock,
  output logic                             alarm,
  output logic                             done,
  output logic                             busy,
  output logic [$clog2(MAX_TRIES+1)-1:0]   fail_cnt
);

  localparam int CW   = CODE_LEN * DIGIT_W;
  localparam int IDXW = $clog2(CODE_LEN + 1);
  localparam int TW   = $clog2(TIMEOUT_CYC + 1);
  localparam int UW   = $clog2(UNLOCK_CYC + 1);
  localparam int FW   = $clog2(MAX_TRIES + 1);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_ENTER    = 3'd1,
    S_CHECK    = 3'd2,
    S_UNLOCKED = 3'd3,
    S_PROG     = 3'd4,
    S_ALARM    = 3'd5
  } state_t;

  // Digit 0 sits in the most significant slot of the code word.
  function automatic logic [DIGIT_W-1:0] get_digit(input logic [CW-1:0] code,
                                                   input logic [IDXW-1:0] idx);
    logic [DIGIT_W-1:0] d;
    d = '0;
    for (int i = 0; i < CODE_LEN; i++) begin
      d = (idx == IDXW'(i)) ? code[(CODE_LEN-1-i)*DIGIT_W +: DIGIT_W] : d;
    end
    return d;
  endfunction

  function automatic logic [CW-1:0] set_digit(input logic [CW-1:0] code,
                                              input logic [IDXW-1:0] idx,
                                              input logic [DIGIT_W-1:0] d);
    logic [CW-1:0] res;
    res = code;
    for (int i = 0; i < CODE_LEN; i++) begin
      res[(CODE_LEN-1-i)*DIGIT_W +: DIGIT_W] =
        (idx == IDXW'(i)) ? d : res[(CODE_LEN-1-i)*DIGIT_W +: DIGIT_W];
    end
    return res;
  endfunction

  state_t          state_r, state_s;
  logic [CW-1:0]   code_r, code_s;
  logic [CW-1:0]   shadow_r, shadow_s;
  logic [IDXW-1:0] idx_r, idx_s;
  logic            mismatch_r, mismatch_s;
  logic [TW-1:0]   timer_r, timer_s;
  logic [UW-1:0]   ucnt_r, ucnt_s;
  logic [FW-1:0]   fail_cnt_r, fail_cnt_s;
  logic            unlock_r, alarm_r, done_r, busy_r;
  logic            prog_done_s;
  logic            last_digit_s;
  logic            timed_out_s;
  logic [FW-1:0]   fail_inc_s;
  logic [CW-1:0]   shadow_wr_s;

  assign last_digit_s = (idx_r == IDXW'(CODE_LEN - 1));
  assign timed_out_s  = (timer_r == TW'(TIMEOUT_CYC));
  assign fail_inc_s   = fail_cnt_r + FW'(1);
  assign shadow_wr_s  = set_digit(shadow_r, idx_r, digit_in);

  // Next-state and datapath update for the lock FSM.
  always_comb begin
    state_s     = state_r;
    code_s      = code_r;
    shadow_s    = shadow_r;
    idx_s       = idx_r;
    mismatch_s  = mismatch_r;
    timer_s     = timer_r;
    ucnt_s      = ucnt_r;
    fail_cnt_s  = fail_cnt_r;
    prog_done_s = 1'b0;

    case (state_r)
      S_IDLE: begin
        if (start) begin
          state_s    = S_ENTER;
          idx_s      = '0;
          mismatch_s = 1'b0;
          timer_s    = '0;
        end else begin
          state_s = S_IDLE;
        end
      end

      S_ENTER: begin
        // A digit on the timeout cycle still counts; it takes priority.
        if (digit_valid) begin
          mismatch_s = mismatch_r | (digit_in != get_digit(code_r, idx_r));
          idx_s      = idx_r + IDXW'(1);
          timer_s    = '0;
          if (last_digit_s) begin
            state_s = S_CHECK;
          end else begin
            state_s = S_ENTER;
          end
        end else if (timed_out_s) begin
          mismatch_s = 1'b1;
          state_s    = S_CHECK;
        end else begin
          timer_s = timer_r + TW'(1);
        end
      end

      S_CHECK: begin
        if (!mismatch_r) begin
          fail_cnt_s = '0;
          ucnt_s     = '0;
          state_s    = S_UNLOCKED;
        end else if (fail_inc_s == FW'(MAX_TRIES)) begin
          fail_cnt_s = fail_inc_s;
          state_s    = S_ALARM;
        end else begin
          fail_cnt_s = fail_inc_s;
          state_s    = S_IDLE;
        end
      end

      S_UNLOCKED: begin
        if (start && prog_mode) begin
          state_s  = S_PROG;
          idx_s    = '0;
          timer_s  = '0;
          shadow_s = '0;
        end else if (ucnt_r == UW'(UNLOCK_CYC - 1)) begin
          state_s = S_IDLE;
        end else begin
          ucnt_s = ucnt_r + UW'(1);
        end
      end

      S_PROG: begin
        if (digit_valid) begin
          shadow_s = shadow_wr_s;
          idx_s    = idx_r + IDXW'(1);
          timer_s  = '0;
          if (last_digit_s) begin
            code_s      = shadow_wr_s;
            prog_done_s = 1'b1;
            state_s     = S_IDLE;
          end else begin
            state_s = S_PROG;
          end
        end else if (timed_out_s) begin
          prog_done_s = 1'b1;
          state_s     = S_IDLE;
        end else begin
          timer_s = timer_r + TW'(1);
        end
      end

      S_ALARM: begin
        if (clear_alarm) begin
          fail_cnt_s = '0;
          state_s    = S_IDLE;
        end else begin
          state_s = S_ALARM;
        end
      end

      default: begin
        state_s = S_IDLE;
      end
    endcase
  end

  // State, code and counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= S_IDLE;
      code_r     <= DEFAULT_CODE;
      shadow_r   <= '0;
      idx_r      <= '0;
      mismatch_r <= 1'b0;
      timer_r    <= '0;
      ucnt_r     <= '0;
      fail_cnt_r <= '0;
    end else begin
      state_r    <= state_s;
      code_r     <= code_s;
      shadow_r   <= shadow_s;
      idx_r      <= idx_s;
      mismatch_r <= mismatch_s;
      timer_r    <= timer_s;
      ucnt_r     <= ucnt_s;
      fail_cnt_r <= fail_cnt_s;
    end
  end

  // Outputs registered from the next state so they align with the state they describe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      unlock_r <= 1'b0;
      alarm_r  <= 1'b0;
      done_r   <= 1'b0;
      busy_r   <= 1'b0;
    end else begin
      unlock_r <= (state_s == S_UNLOCKED);
      alarm_r  <= (state_s == S_ALARM);
      done_r   <= (state_s == S_CHECK) | prog_done_s;
      busy_r   <= (state_s == S_ENTER) | (state_s == S_CHECK) | (state_s == S_PROG);
    end
  end

  assign unlock   = unlock_r;
  assign alarm    = alarm_r;
  assign done     = done_r;
  assign busy     = busy_r;
  assign fail_cnt = fail_cnt_r;

endmodule

// File: tb/tb_param_digital_lock.sv
// Directed bench for param_digital_lock: attempt outcomes go through a scoreboard queue,
// timing edges (CHECK cycle, unlock width, timeout boundary, async reset) are checked inline.
module tb_param_digital_lock;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       prog_mode = 1'b0;
  logic [3:0] digit_in = 4'd0;
  logic       digit_valid = 1'b0;
  logic       clear_alarm = 1'b0;
  logic       unlock, alarm, done, busy;
  logic [1:0] fail_cnt;

  int n_pass = 0;
  int n_total = 0;

  typedef struct {
    logic       unl;
    logic       alm;
    logic [1:0] fc;
  } exp_t;
  exp_t sb_q[$];

  param_digital_lock #(
    .DIGIT_W(4), .CODE_LEN(4), .DEFAULT_CODE(16'h1001),
    .MAX_TRIES(3), .TIMEOUT_CYC(16), .UNLOCK_CYC(8)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .prog_mode(prog_mode),
    .digit_in(digit_in), .digit_valid(digit_valid), .clear_alarm(clear_alarm),
    .unlock(unlock), .alarm(alarm), .done(done), .busy(busy), .fail_cnt(fail_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic u, input logic a, input logic [1:0] f);
    exp_t e;
    e.unl = u;
    e.alm = a;
    e.fc  = f;
    sb_q.push_back(e);
  endtask

  task automatic send_digit(input logic [3:0] d);
    digit_valid = 1'b1;
    digit_in    = d;
    tick;
    digit_valid = 1'b0;
  endtask

  task automatic entry(input logic [15:0] code);
    start = 1'b1;
    tick;
    start = 1'b0;
    for (int i = 0; i < 4; i++) send_digit(code[15-4*i -: 4]);
  endtask

  task automatic wait_done(input string tag, input int budget);
    int n;
    n = 0;
    while (done !== 1'b1 && n < budget) begin
      tick;
      n++;
    end
    chk(tag, done, 1);
  endtask

  // One cycle after CHECK the attempt outcome is visible; compare it with the queued expectation.
  task automatic check_outcome(input string tag);
    exp_t e;
    tick;
    if (sb_q.size() == 0) begin
      chk({tag, "_sb_empty"}, 0, 1);
    end else begin
      e = sb_q.pop_front();
      chk({tag, "_unlock"}, unlock, e.unl);
      chk({tag, "_alarm"}, alarm, e.alm);
      chk({tag, "_fail_cnt"}, fail_cnt, e.fc);
    end
  endtask

  task automatic attempt(input string tag, input logic [15:0] code,
                         input logic u, input logic a, input logic [1:0] f);
    push(u, a, f);
    entry(code);
    wait_done({tag, "_done"}, 0);
    chk({tag, "_busy_check"}, busy, 1);
    check_outcome(tag);
  endtask

  task automatic wait_unlock_end(input string tag);
    int n;
    n = 0;
    while (unlock === 1'b1 && n < 20) begin
      tick;
      n++;
    end
    chk(tag, unlock, 0);
  endtask

  initial begin
    int w;
    // reset state
    #3;
    chk("rst_unlock", unlock, 0);
    chk("rst_alarm", alarm, 0);
    chk("rst_done", done, 0);
    chk("rst_busy", busy, 0);
    chk("rst_fail_cnt", fail_cnt, 0);
    tick;
    tick;
    rst_n = 1'b1;
    tick;

    // correct entry with the default code, unlock held for exactly 8 cycles
    attempt("ok1", 16'h1001, 1'b1, 1'b0, 2'd0);
    w = 0;
    while (unlock === 1'b1 && w < 20) begin
      w++;
      tick;
    end
    chk("unlock_width", w, 8);

    // three wrong entries lead to alarm
    attempt("bad1", 16'h1110, 1'b0, 1'b0, 2'd1);
    attempt("bad2", 16'h1110, 1'b0, 1'b0, 2'd2);
    attempt("bad3", 16'h1110, 1'b0, 1'b1, 2'd3);
    start = 1'b1;
    tick;
    start = 1'b0;
    chk("alarm_start_ignored_busy", busy, 0);
    chk("alarm_held", alarm, 1);
    send_digit(4'd1);
    chk("alarm_digit_ignored", fail_cnt, 3);
    clear_alarm = 1'b1;
    tick;
    clear_alarm = 1'b0;
    chk("clear_alarm", alarm, 0);
    chk("clear_fail_cnt", fail_cnt, 0);

    // inter-digit timeout counts as a failure
    push(1'b0, 1'b0, 2'd1);
    start = 1'b1;
    tick;
    start = 1'b0;
    send_digit(4'd1);
    send_digit(4'd0);
    repeat (15) tick;
    chk("to_no_early_done", done, 0);
    wait_done("to_done", 4);
    check_outcome("to");

    // digit arriving on the timer==TIMEOUT_CYC cycle is accepted
    push(1'b1, 1'b0, 2'd0);
    start = 1'b1;
    tick;
    start = 1'b0;
    send_digit(4'd1);
    send_digit(4'd0);
    repeat (16) tick;
    chk("edge_still_busy", busy, 1);
    chk("edge_no_done", done, 0);
    send_digit(4'd0);
    send_digit(4'd1);
    chk("edge_done", done, 1);
    check_outcome("edge");
    wait_unlock_end("edge_unlock_end");

    // reprogram timeout keeps the old code
    attempt("pto_open", 16'h1001, 1'b1, 1'b0, 2'd0);
    start = 1'b1;
    prog_mode = 1'b0;
    tick;
    chk("prog0_ignored_unlock", unlock, 1);
    chk("prog0_ignored_busy", busy, 0);
    prog_mode = 1'b1;
    tick;
    start = 1'b0;
    prog_mode = 1'b0;
    chk("prog_unlock_drop", unlock, 0);
    chk("prog_busy", busy, 1);
    send_digit(4'd2);
    send_digit(4'd2);
    wait_done("pto_done", 25);
    chk("pto_idle", busy, 0);
    attempt("pto_keep", 16'h1001, 1'b1, 1'b0, 2'd0);

    // reprogram to 3,5,7,9 from the unlocked state
    start = 1'b1;
    prog_mode = 1'b1;
    tick;
    start = 1'b0;
    prog_mode = 1'b0;
    send_digit(4'd3);
    send_digit(4'd5);
    send_digit(4'd7);
    send_digit(4'd9);
    chk("prog_done", done, 1);
    chk("prog_unlock_low", unlock, 0);
    attempt("old_code", 16'h1001, 1'b0, 1'b0, 2'd1);
    attempt("new_code", 16'h3579, 1'b1, 1'b0, 2'd0);
    wait_unlock_end("new_unlock_end");

    // async reset mid-entry restores the default code
    start = 1'b1;
    tick;
    start = 1'b0;
    send_digit(4'd3);
    chk("pre_rst_busy", busy, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_unlock", unlock, 0);
    chk("arst_alarm", alarm, 0);
    chk("arst_done", done, 0);
    chk("arst_busy", busy, 0);
    chk("arst_fail_cnt", fail_cnt, 0);
    tick;
    rst_n = 1'b1;
    tick;
    attempt("rst_new_fails", 16'h3579, 1'b0, 1'b0, 2'd1);
    attempt("rst_default_ok", 16'h1001, 1'b1, 1'b0, 2'd0);
    wait_unlock_end("final_unlock_end");
    chk("sb_drained", sb_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/param_digital_lock.md
Name: param_digital_lock

Overview:
- Generalised digital lock: one FSM plus code, attempt and timer registers in a single block.
- Replaces the fixed 4-bit single-compare lock with a configurable digit width, code length, retry limit, inter-digit timeout, timed unlock window and in-field code reprogramming.
- Sits between the keypad digit source and the actuator/alarm drivers.

Parameters:
- DIGIT_W, 4, width of one entered digit.
- CODE_LEN, 4, digits per code.
- DEFAULT_CODE, 16'h1001, code loaded at reset; width CODE_LEN*DIGIT_W; digit 0 is the MS digit.
- MAX_TRIES, 3, consecutive failed attempts that raise alarm (>=1).
- TIMEOUT_CYC, 16, max cycles between accepted digits in ENTER/PROG.
- UNLOCK_CYC, 8, cycles unlock stays high.

Ports:
- clk, input, 1, rising-edge clock.
- rst_n, input, 1, asynchronous active-low reset.
- start, input, 1, begin an entry (IDLE) or programming (UNLOCKED with prog_mode=1).
- prog_mode, input, 1, qualifies start in UNLOCKED.
- digit_in, input, DIGIT_W, digit value.
- digit_valid, input, 1, digit_in valid this cycle.
- clear_alarm, input, 1, leaves ALARM.
- unlock, output, 1, lock open.
- alarm, output, 1, alarm active.
- done, output, 1, one-cycle pulse at end of each attempt or programming sequence.
- busy, output, 1, high in ENTER, CHECK, PROG.
- fail_cnt, output, $clog2(MAX_TRIES+1), consecutive failures.

Behaviour:
- Reset (async, rst_n=0): state=IDLE, code_reg=DEFAULT_CODE, fail_cnt=0, digit index=0, timers=0. unlock, alarm, done and busy are all 0.
- IDLE: start=1 -> ENTER; idx=0, mismatch=0, timer=0. digit_valid ignored.
- ENTER, digit_valid=1:
  - Compare digit_in against code_reg digit idx; mismatch is sticky OR.
  - idx++, timer=0.
  - On the CODE_LEN-th digit -> CHECK.
  - start is ignored in ENTER.
- ENTER, no digit: timer++. When timer reaches TIMEOUT_CYC -> CHECK with mismatch forced to 1, so a timeout counts as a failure.
- CHECK (1 cycle), done=1:
  - Match: fail_cnt=0 -> UNLOCKED.
  - Mismatch: fail_cnt++. If the new value equals MAX_TRIES -> ALARM, else -> IDLE.
- Timing: unlock rises the cycle after CHECK. Latency from last digit to unlock is 2 cycles.
- UNLOCKED:
  - unlock=1 for UNLOCK_CYC cycles, then -> IDLE.
  - start=1 with prog_mode=1 -> PROG (idx=0, timer=0, shadow cleared); unlock drops.
  - start=1 with prog_mode=0 is ignored.
- PROG:
  - Each digit_valid writes digit idx of the shadow register.
  - After CODE_LEN digits: code_reg<=shadow, done=1, -> IDLE.
  - Timeout -> IDLE with done=1 and code_reg unchanged, so the old code is kept.
- ALARM: alarm=1 and all inputs except clear_alarm are ignored. clear_alarm=1 -> IDLE, fail_cnt=0, alarm drops next cycle.
- Simultaneous events:
  - A digit arriving on the same cycle as timer==TIMEOUT_CYC is accepted; the digit wins.
  - clear_alarm outside ALARM has no effect.
- Reset mid-operation: immediate return to the reset values. A reprogrammed code is lost; DEFAULT_CODE is reloaded.
- Widths: idx is $clog2(CODE_LEN+1) bits. Timers saturate and never wrap.

Test Plan:
- Correct entry: defaults; start, then digits 1,0,0,1 on consecutive cycles -> done pulse, unlock=1 for exactly 8 cycles from 2 cycles after the last digit, fail_cnt=0.
- Wrong entry ×3:
  - Enter 1,1,1,0 three times -> fail_cnt 1, 2, then alarm=1 after the third CHECK.
  - A fourth start is ignored.
  - clear_alarm -> alarm=0, fail_cnt=0.
- Timeout:
  - start, digits 1,0, then idle 16 cycles -> done, fail_cnt=1, no unlock.
  - A digit arriving exactly at cycle 16 is accepted and no timeout occurs.
- Reprogram:
  - Unlock, then start+prog_mode, enter 3,5,7,9 -> done.
  - Code 1,0,0,1 now fails; code 3,5,7,9 unlocks.
- Reprogram timeout: after 2 PROG digits, idle 16 cycles -> 1,0,0,1 still unlocks.
- Async reset:
  - Assert rst_n=0 between clock edges mid-ENTER -> all outputs 0 immediately.
  - After a reprogram, reset restores DEFAULT_CODE; a success after one failure clears fail_cnt to 0.
